// File: rtl/term_src_fifo_if.sv
// Driver/mesh-side bundle for term_src_fifo; drop_cnt exists only when
// TERM_SRC_ADDR_CHECK_EN is defined.
interface term_src_fifo_if #(
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4
);
   localparam int CNT_W = $clog2(fifo_depth) + 1;

   logic               push;
   logic [pckg_sz-1:0] data_in;
   logic               full;
   logic [CNT_W-1:0]   count;
   logic               pndng;
   logic [pckg_sz-1:0] data_out;
   logic               popin;
   logic               overflow;
   logic               underflow;
   logic [15:0]        pkt_cnt;
`ifdef TERM_SRC_ADDR_CHECK_EN
   logic [15:0]        drop_cnt;

   modport master (
      output push, data_in, popin,
      input  full, count, pndng, data_out, overflow, underflow, pkt_cnt, drop_cnt
   );
   modport slave (
      input  push, data_in, popin,
      output full, count, pndng, data_out, overflow, underflow, pkt_cnt, drop_cnt
   );
`else
   modport master (
      output push, data_in, popin,
      input  full, count, pndng, data_out, overflow, underflow, pkt_cnt
   );
   modport slave (
      input  push, data_in, popin,
      output full, count, pndng, data_out, overflow, underflow, pkt_cnt
   );
`endif
endinterface

// File: rtl/term_src_fifo.sv
// Terminal injection FIFO: 1-cycle push-to-pndng, show-ahead head; refused pushes set sticky overflow.
// Optional destination check (row/col must be a mesh edge terminal) under TERM_SRC_ADDR_CHECK_EN.
module term_src_fifo #(
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4,
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4
) (
   input  logic           clk,
   input  logic           reset,
   term_src_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(fifo_depth);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(fifo_depth);

   logic [pckg_sz-1:0] mem_q [fifo_depth];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic [15:0]      pkt_cnt_q, pkt_cnt_d;

   logic               full;
   logic               pndng;
   logic               pop_eff;
   logic               push_ok;
   logic               accept;
   logic [pckg_sz-1:0] store_dat;

   assign full      = (count_q == DEPTH_C);
   assign pndng     = (count_q != '0);
   assign pop_eff   = bus.popin && pndng;
   assign accept    = push_ok && (!full || pop_eff);
   // Next-jump is owned by the mesh; the terminal always injects it as zero.
   assign store_dat = {8'h00, bus.data_in[pckg_sz-9:0]};

`ifdef TERM_SRC_ADDR_CHECK_EN
   localparam logic [3:0] ROW_MAX  = 4'(ROWS);
   localparam logic [3:0] COL_MAX  = 4'(COLUMS);
   localparam logic [3:0] ROW_EDGE = 4'(ROWS + 1);
   localparam logic [3:0] COL_EDGE = 4'(COLUMS + 1);

   logic [3:0]  dst_row;
   logic [3:0]  dst_col;
   logic        dest_ok;
   logic        drop;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   assign dst_row = bus.data_in[pckg_sz-9 -: 4];
   assign dst_col = bus.data_in[pckg_sz-13 -: 4];

   // Only the ring of terminals around the mesh is addressable, corners excluded.
   always_comb begin
      dest_ok = 1'b0;
      if ((dst_row == 4'd0 || dst_row == ROW_EDGE) &&
          dst_col >= 4'd1 && dst_col <= COL_MAX) begin
         dest_ok = 1'b1;
      end
      if ((dst_col == 4'd0 || dst_col == COL_EDGE) &&
          dst_row >= 4'd1 && dst_row <= ROW_MAX) begin
         dest_ok = 1'b1;
      end
   end

   assign push_ok = bus.push && dest_ok;
   assign drop    = bus.push && !dest_ok;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.drop_cnt = drop_cnt_q;
`else
   assign push_ok = bus.push;
`endif

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pkt_cnt_d   = pkt_cnt_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end

      unique case ({accept, pop_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (push_ok && !accept) begin
         overflow_d = 1'b1;
      end
      if (bus.popin && !pndng) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pkt_cnt_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pkt_cnt_q   <= pkt_cnt_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately not reset; emptiness is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         mem_q[wr_ptr_q] <= store_dat;
      end
   end

   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.pndng     = pndng;
   assign bus.data_out  = pndng ? mem_q[rd_ptr_q] : '0;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
   assign bus.pkt_cnt   = pkt_cnt_q;

endmodule
